// File: rtl/median_arbiter.sv
// median_arbiter: round-robin sequencer sharing one MEDIAN datapath between NREQ window producers.
// Latency: GNT and first STB one cycle after REQ is sampled in IDLE; 9 feed cycles; RVLD one cycle after MED_DSO.
// Backpressure: REQ is a level held until served, STB paces samples; results are a one-cycle RVLD pulse with no stall.
// Optional: define MEDIAN_ARB_TIMEOUT_EN to add the WAIT watchdog (TMO cycles) and the sticky ERR flag.
module median_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int TMO  = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*W-1:0] DIN,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   STB,
  output logic [W-1:0]      RES,
  output logic [NREQ-1:0]   RVLD,
  output logic [W-1:0]      MED_DI,
  output logic              MED_DSI,
  input  logic [W-1:0]      MED_DO,
  input  logic              MED_DSO,
  output logic              ERR
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [PW-1:0] last;
  logic [PW-1:0] gidx;
  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  logic          tmo_hit;

  // Round-robin search upward from last+1; later hits overwrite, so the nearest requester wins
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (REQ[(int'(last) + i) % NREQ]) begin
        pick_vld = 1'b1;
        pick_idx = PW'((int'(last) + i) % NREQ);
      end
    end
  end

  // Next-state logic; a watchdog expiry in WAIT skips DONE and returns straight to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_vld) state_nxt = FEED;
      FEED:    if (cnt == 4'd8) state_nxt = WAIT;
      WAIT: begin
        if (MED_DSO)      state_nxt = DONE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the sample mux is gated so MED_DI is 0 outside a window
  always_comb begin
    MED_DSI = (state == FEED);
    STB     = MED_DSI ? GNT : '0;
    RVLD    = (state == DONE) ? GNT : '0;
    MED_DI  = MED_DSI ? DIN[int'(gidx)*W +: W] : '0;
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant, round-robin pointer and feed counter; the pointer moves at grant time
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      GNT  <= '0;
      gidx <= '0;
      last <= PW'(NREQ - 1);
      cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: if (pick_vld) begin
          GNT  <= NREQ'(1) << pick_idx;
          gidx <= pick_idx;
          last <= pick_idx;
          cnt  <= '0;
        end
        FEED:    cnt <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
        WAIT:    if (!MED_DSO && tmo_hit) GNT <= '0;
        DONE:    GNT <= '0;
        default: GNT <= '0;
      endcase
    end
  end

  // Result capture; RES holds until the next window's median arrives
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                          RES <= '0;
    else if (state == WAIT && MED_DSO)  RES <= MED_DO;
  end

`ifdef MEDIAN_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] wcnt;

  // wcnt is 0 in the first WAIT cycle, so the hit lands on the TMO-th WAIT cycle
  assign tmo_hit = (state == WAIT) && (wcnt == TW'(TMO - 1));

  // WAIT watchdog and sticky timeout flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wcnt <= '0;
      ERR  <= 1'b0;
    end else begin
      if (state != WAIT)  wcnt <= '0;
      else if (!MED_DSO)  wcnt <= wcnt + TW'(1);
      if (tmo_hit && !MED_DSO) ERR <= 1'b1;
    end
  end
`else
  // No watchdog: WAIT lasts until MED_DSO arrives
  assign tmo_hit = 1'b0;
  assign ERR     = 1'b0;

  if (TMO < 1) begin : g_tmo_range
    $error("median_arbiter: TMO must be at least 1");
  end
`endif

endmodule

// File: doc/median_arbiter.md
Name: median_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one MEDIAN instance between NREQ requesters.
- A granted requester streams a 9-sample window through the arbiter into MEDIAN (DSI framing).
- The arbiter waits for MEDIAN's DSO, then returns the median to that requester with a one-cycle valid.
- Sits between the pixel-window producers and the single MEDIAN datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, sample width; must match MEDIAN DI/DO.
- TMO, 64, watchdog limit in cycles spent in WAIT (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- REQ  in  NREQ  per-requester request level.
- DIN  in  NREQ*W  packed requester samples; requester i owns bits [i*W +: W].
- GNT  out  NREQ  one-hot grant, held for the whole transaction.
- STB  out  NREQ  sample-consumed strobe; requester advances to its next sample after the edge.
- RES  out  W  median result.
- RVLD  out  NREQ  one-hot one-cycle result valid.
- MED_DI  out  W  to MEDIAN DI.
- MED_DSI  out  1  to MEDIAN DSI.
- MED_DO  in  W  from MEDIAN DO.
- MED_DSO  in  1  from MEDIAN DSO.
- ERR  out  1  timeout flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset: state IDLE; GNT, STB, RVLD, RES, MED_DI, MED_DSI, ERR all 0; sample counter 0; last-grant pointer NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, FEED, WAIT, DONE.
- IDLE:
  - If any REQ bit is set, select the first set bit searching upward from last+1 modulo NREQ.
  - Register GNT one-hot, update the pointer, enter FEED at the next edge.
  - REQ is sampled only in IDLE.
- FEED: lasts exactly 9 cycles, counter 0..8.
  - MED_DSI=1.
  - MED_DI = DIN slice of the granted requester (combinational mux, gated to 0 when not in FEED).
  - STB = GNT each cycle.
  - Counter = 8 -> WAIT.
  - REQ deassertion is ignored; the transaction always completes.
  - MED_DSO during FEED is ignored.
- WAIT:
  - MED_DSI=0, STB=0, GNT held.
  - On MED_DSO=1: capture MED_DO into RES, enter DONE.
- DONE (1 cycle):
  - RVLD = GNT; RES stable.
  - GNT clears at the exit edge; next state IDLE.
  - RES holds until the next capture.
- Framing: MED_DSI is low for at least 2 cycles between windows (DONE + IDLE).
- Latency:
  - REQ high in IDLE at edge t -> GNT/first STB in cycle t+1; last STB at t+9.
  - RVLD one cycle after DSO is seen.
  - Back-to-back throughput is 9 + MEDIAN latency + 2 cycles per window.
- Simultaneous requests: exactly one grant; the loser keeps REQ high and wins next.
- Requester fairness: with all requesters active, grants follow 0,1,..,NREQ-1,0.
- No combinational path from REQ to GNT.
- Reset mid-operation: immediate return to reset values; the partially fed window is discarded. The MEDIAN instance shares nRST.

Optional Feature:
- MEDIAN_ARB_TIMEOUT_EN defined:
  - A WAIT-cycle counter runs while in WAIT.
  - When it reaches TMO without MED_DSO: set ERR (sticky until reset), skip DONE (no RVLD), clear GNT, go to IDLE.
  - The pointer still advances past the stalled requester.
- Not defined: no counter; WAIT lasts indefinitely; ERR tied 0.

Test Plan:
- Single requester: REQ=0001, DIN samples 9,1,8,2,7,3,6,4,5 -> MED_DI sequence matches with MED_DSI high 9 cycles, STB[0] 9 pulses, then RVLD=0001 with RES=5.
- Simultaneous REQ=0110 after reset -> requester 1 granted first, then requester 2. Each gets the median of its own 9 samples; RVLD order 0010 then 0100.
- REQ=1111 held for 8 transactions with random windows (checked by software sort) -> grant order 0,1,2,3,0,1,2,3; MED_DSI low ≥2 cycles between windows.
- Requester 2 drops REQ after the 3rd STB -> all 9 STB still issued, RVLD=0100, correct median.
- nRST pulsed low during the 5th FEED cycle -> all outputs 0 asynchronously. The next REQ=0001 completes normally with a correct RES.
- With MEDIAN_ARB_TIMEOUT_EN, TMO=16, MED_DSO forced 0 -> ERR=1 exactly 16 cycles into WAIT, no RVLD, GNT cleared. The next requester is still served correctly.
